// File: rtl/neptune_gate_sequencer.sv
// neptune_gate_sequencer: gates a clk_config-selected window, counts input_pulse rises and
// publishes the count over valid/ready. Define NEPTUNE_SEQ_GLITCH_FILTER_EN for the high-time filter.
module neptune_gate_sequencer #(
  parameter int COUNT_W    = 12,
  parameter int WIN0       = 1000,
  parameter int WIN1       = 2000,
  parameter int WIN2       = 4000,
  parameter int WIN3       = 3200,
  parameter int GLITCH_CYC = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         clk_config,
  input  logic               input_pulse,
  input  logic               enable,
  output logic [COUNT_W-1:0] count,
  output logic               count_valid,
  input  logic               count_ready,
  output logic               overflow,
  output logic               busy
);

  localparam int WIN_MAX01 = (WIN0 > WIN1) ? WIN0 : WIN1;
  localparam int WIN_MAX23 = (WIN2 > WIN3) ? WIN2 : WIN3;
  localparam int WIN_MAX   = (WIN_MAX01 > WIN_MAX23) ? WIN_MAX01 : WIN_MAX23;
  localparam int TIMER_W   = (WIN_MAX > 2) ? $clog2(WIN_MAX) : 1;
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_COUNT   = 2'b01,
    S_PRESENT = 2'b10
  } state_t;

  state_t               state_r, state_next_s;
  logic                 start_s, publish_s;
  logic                 sync1_r, sync2_r;
  logic                 rise_s;
  logic [TIMER_W-1:0]   timer_r;
  logic [COUNT_W-1:0]   edge_cnt_r, edge_cnt_next_s;
  logic                 sat_r, sat_next_s;

  // Timer reload value is the window length minus one, so timer==0 marks the last gate cycle.
  function automatic logic [TIMER_W-1:0] win_load(input logic [1:0] sel);
    case (sel)
      2'b00:   win_load = TIMER_W'(WIN0 - 1);
      2'b01:   win_load = TIMER_W'(WIN1 - 1);
      2'b10:   win_load = TIMER_W'(WIN2 - 1);
      default: win_load = TIMER_W'(WIN3 - 1);
    endcase
  endfunction

  // Two-flop synchronizer for the asynchronous pulse input
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= input_pulse;
      sync2_r <= sync1_r;
    end
  end

`ifdef NEPTUNE_SEQ_GLITCH_FILTER_EN
  localparam int RUN_W = $clog2(GLITCH_CYC + 1);
  logic [RUN_W-1:0] run_r;

  // Consecutive-high run length of the synchronized input, saturating at GLITCH_CYC
  always_ff @(posedge clk) begin
    if (rst) begin
      run_r <= {RUN_W{1'b0}};
    end else if (!sync2_r) begin
      run_r <= {RUN_W{1'b0}};
    end else if (run_r != RUN_W'(GLITCH_CYC)) begin
      run_r <= run_r + RUN_W'(1);
    end else begin
      run_r <= run_r;
    end
  end

  // Fires once per high period, on the GLITCH_CYC-th consecutive high cycle.
  assign rise_s = sync2_r && (run_r == RUN_W'(GLITCH_CYC - 1));
`else
  logic prev_r;

  // Previous synchronized level for 0->1 detection
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= sync2_r;
    end
  end

  assign rise_s = sync2_r & ~prev_r;
`endif

  // Saturating edge counter increment; sat flags a rise lost at full scale
  always_comb begin
    edge_cnt_next_s = edge_cnt_r;
    sat_next_s      = sat_r;
    if (rise_s) begin
      if (edge_cnt_r == CNT_MAX) begin
        sat_next_s = 1'b1;
      end else begin
        edge_cnt_next_s = edge_cnt_r + COUNT_W'(1);
      end
    end else begin
      edge_cnt_next_s = edge_cnt_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state and window start/publish strobes
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    publish_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (enable) begin
          state_next_s = S_COUNT;
          start_s      = 1'b1;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_COUNT: begin
        // Dropping enable abandons the window even on its final cycle.
        if (!enable) begin
          state_next_s = S_IDLE;
        end else if (timer_r == {TIMER_W{1'b0}}) begin
          state_next_s = S_PRESENT;
          publish_s    = 1'b1;
        end else begin
          state_next_s = S_COUNT;
        end
      end
      S_PRESENT: begin
        if (count_ready) begin
          if (enable) begin
            state_next_s = S_COUNT;
            start_s      = 1'b1;
          end else begin
            state_next_s = S_IDLE;
          end
        end else begin
          state_next_s = S_PRESENT;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Gate timer, edge counter and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_r     <= {TIMER_W{1'b0}};
      edge_cnt_r  <= {COUNT_W{1'b0}};
      sat_r       <= 1'b0;
      count       <= {COUNT_W{1'b0}};
      overflow    <= 1'b0;
      count_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      count_valid <= (state_next_s == S_PRESENT);
      busy        <= (state_next_s == S_COUNT);
      if (start_s) begin
        timer_r    <= win_load(clk_config);
        edge_cnt_r <= {COUNT_W{1'b0}};
        sat_r      <= 1'b0;
      end else if (state_r == S_COUNT) begin
        timer_r    <= timer_r - TIMER_W'(1);
        edge_cnt_r <= edge_cnt_next_s;
        sat_r      <= sat_next_s;
      end else begin
        timer_r    <= timer_r;
        edge_cnt_r <= edge_cnt_r;
        sat_r      <= sat_r;
      end
      // The publish value includes a rise landing on the final gate cycle.
      if (publish_s) begin
        count    <= edge_cnt_next_s;
        overflow <= sat_next_s;
      end else begin
        count    <= count;
        overflow <= overflow;
      end
    end
  end

endmodule

// File: tb/tb_neptune_gate_sequencer.sv
// Scoreboard bench for neptune_gate_sequencer: a window-level reference model predicts
// results and per-cycle busy/valid; a monitor compares them against the DUT.
module tb_neptune_gate_sequencer;

  localparam int CW   = 4;
  localparam int W0   = 16;
  localparam int W1   = 32;
  localparam int W2   = 8;
  localparam int W3   = 20;
  localparam int GC   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    clk_config = 2'b00;
  logic          input_pulse = 1'b0;
  logic          enable = 1'b0;
  logic          count_ready = 1'b1;
  logic [CW-1:0] count;
  logic          count_valid;
  logic          overflow;
  logic          busy;

  typedef struct packed {
    logic [CW-1:0] c;
    logic          o;
  } res_t;

  res_t exp_q[$];
  bit   pulse_q[$];
  int   pulse_mode = 0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   n_results = 0;
  int   last_count = -1;
  int   last_ovf = -1;
  int   last_gap = 0;
  bit   m_busy = 1'b0;
  bit   m_valid = 1'b0;

  neptune_gate_sequencer #(
    .COUNT_W(CW), .WIN0(W0), .WIN1(W1), .WIN2(W2), .WIN3(W3), .GLITCH_CYC(GC)
  ) u_dut (
    .clk(clk), .rst(rst), .clk_config(clk_config), .input_pulse(input_pulse),
    .enable(enable), .count(count), .count_valid(count_valid),
    .count_ready(count_ready), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  function automatic int win_of(input logic [1:0] c);
    case (c)
      2'b00:   return W0;
      2'b01:   return W1;
      2'b10:   return W2;
      default: return W3;
    endcase
  endfunction

  // Pulse source: queued pattern bits take priority over the background mode.
  initial begin : pulse_drv
    forever begin
      @(posedge clk);
      #2;
      if (pulse_q.size() > 0) input_pulse = pulse_q.pop_front();
      else begin
        case (pulse_mode)
          1:       input_pulse = (cyc % 4 != 0);
          2:       input_pulse = ~input_pulse;
          3:       input_pulse = 1'($urandom_range(0, 1));
          default: input_pulse = 1'b0;
        endcase
      end
    end
  end

  // Reference model: h[i] is the pulse level i cycles ago; a counted rise in a cycle
  // reflects the input two cycles earlier. Rises are tallied as an unbounded integer.
  initial begin : model
    int mode;
    int left;
    int rises;
    bit rise;
    bit h[0:5];
    res_t r;
    mode = 0; left = 0; rises = 0;
    for (int i = 0; i < 6; i++) h[i] = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        mode = 0;
        for (int i = 0; i < 6; i++) h[i] = 1'b0;
      end else begin
        for (int i = 5; i > 0; i--) h[i] = h[i-1];
        h[0] = input_pulse;
`ifdef NEPTUNE_SEQ_GLITCH_FILTER_EN
        rise = h[2] & h[3] & h[4] & ~h[5];
`else
        rise = h[2] & ~h[3];
`endif
        case (mode)
          0: if (enable) begin mode = 1; left = win_of(clk_config); rises = 0; end
          1: begin
            if (!enable) mode = 0;
            else begin
              rises += int'(rise);
              left--;
              if (left == 0) begin
                r.c = (rises > CMAX) ? CW'(CMAX) : CW'(rises);
                r.o = (rises > CMAX);
                exp_q.push_back(r);
                mode = 2;
              end
            end
          end
          default: if (count_ready) begin
            if (enable) begin mode = 1; left = win_of(clk_config); rises = 0; end
            else mode = 0;
          end
        endcase
      end
      m_busy  = (mode == 1);
      m_valid = (mode == 2);
    end
  end

  // Monitor: per-cycle busy/valid checks; a new result is popped when count_valid rises.
  initial begin : monitor
    res_t cur;
    bit   prev_v;
    int   last_rise;
    cur = '0; prev_v = 1'b0; last_rise = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cur = '0;
        prev_v = 1'b0;
        exp_q.delete();
      end else begin
        chk("busy", int'(busy), int'(m_busy));
        chk("count_valid", int'(count_valid), int'(m_valid));
        if (count_valid && !prev_v) begin
          if (exp_q.size() == 0) timeout_fail("unexpected_result");
          else cur = exp_q.pop_front();
          n_results++;
          last_count = int'(count);
          last_ovf = int'(overflow);
          last_gap = cyc - last_rise;
          last_rise = cyc;
        end
        chk("count", int'(count), int'(cur.c));
        chk("overflow", int'(overflow), int'(cur.o));
        prev_v = count_valid;
      end
    end
  end

  task automatic wait_results(input int target, input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (n_results >= target) return;
    end
    timeout_fail(name);
  endtask

  task automatic wait_busy_rise(input string name);
    bit seen_low;
    seen_low = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (!busy) seen_low = 1'b1;
      else if (seen_low) return;
    end
    timeout_fail(name);
  endtask

  task automatic busy_len(input int start_len, output int len);
    len = start_len;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (busy) len++;
      else return;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int len;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_count", int'(count), 0);
    chk("reset_valid", int'(count_valid), 0);
    chk("reset_busy", int'(busy), 0);

    // cfg 00, period-4 pulses, ready high
    pulse_mode = 1;
    step(1);
    enable = 1'b1;
    wait_results(4, "t1_results");
    chk("t1_count", last_count, 4);
    chk("t1_ovf", last_ovf, 0);
    chk("t1_period", last_gap, W0 + 1);

    // cfg 10, result held while ready is low
    clk_config = 2'b10;
    wait_results(n_results + 2, "t2_results");
    chk("t2_count", last_count, 2);
    step(1);
    count_ready = 1'b0;
    wait_results(n_results + 1, "t2_hold");
    repeat (10) @(negedge clk);
    #1;
    chk("t2_held_valid", int'(count_valid), 1);
    chk("t2_held_busy", int'(busy), 0);
    chk("t2_held_count", int'(count), 2);
    @(posedge clk);
    #1;
    count_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("t2_released", int'(count_valid), 0);

    // cfg 01, toggling pulse saturates the counter
    clk_config = 2'b01;
    pulse_mode = 2;
    wait_results(n_results + 3, "t3_results");
`ifdef NEPTUNE_SEQ_GLITCH_FILTER_EN
    chk("t3_count", last_count, 0);
    chk("t3_ovf", last_ovf, 0);
`else
    chk("t3_count", last_count, CMAX);
    chk("t3_ovf", last_ovf, 1);
`endif
    step(1);
    enable = 1'b0;
    pulse_mode = 0;
    step(6);
    enable = 1'b1;
    for (int i = 0; i < 12; i++) pulse_q.push_back((i % 8) < 4);
    wait_results(n_results + 1, "t3b_results");
    chk("t3b_count", last_count, 2);
    chk("t3b_ovf", last_ovf, 0);

    // enable dropped 5 cycles into a window
    wait_busy_rise("t4_busy");
    step(5);
    enable = 1'b0;
    len = n_results;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("t4_busy_low", int'(busy), 0);
    step(30);
    chk("t4_no_result", n_results, len);
    enable = 1'b1;
    wait_results(n_results + 1, "t4_fresh");

    // cfg change mid-window takes effect at the next window
    step(1);
    enable = 1'b0;
    step(3);
    clk_config = 2'b00;
    enable = 1'b1;
    wait_busy_rise("t5_busy");
    step(5);
    clk_config = 2'b11;
    busy_len(5, len);
    chk("t5_win_cur", len, W0);
    wait_busy_rise("t5_busy2");
    busy_len(1, len);
    chk("t5_win_next", len, W3);

    // glitch filter pattern: 1-, 2- and 3-cycle highs
    step(1);
    enable = 1'b0;
    step(4);
    clk_config = 2'b01;
    enable = 1'b1;
    pulse_q = '{0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    wait_results(n_results + 1, "t6_results");
`ifdef NEPTUNE_SEQ_GLITCH_FILTER_EN
    chk("t6_count", last_count, 1);
`else
    chk("t6_count", last_count, 3);
`endif

    // randomized traffic checked by the model
    pulse_mode = 3;
    for (int i = 0; i < 2000; i++) begin
      step(1);
      count_ready = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 9) == 0) clk_config = 2'($urandom_range(0, 3));
    end

    // reset in the middle of a window
    count_ready = 1'b1;
    enable = 1'b1;
    wait_busy_rise("t8_busy");
    step(4);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    #1;
    chk("t8_rst_valid", int'(count_valid), 0);
    chk("t8_rst_count", int'(count), 0);
    step(40);
    chk("drain_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
